// File: rtl/mlp_pkg.sv
// Shared types, constants and helpers for the two-layer fp32 perceptron.
// Holds the fp32 word type, the FSM state enum, fp32 constants and relu().
package mlp_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    L1,
    L2,
    DONE
  } mlp_state_e;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_QNAN = 32'h7FC0_0000;
  localparam fp32_t FP32_PINF = 32'h7F80_0000;
  localparam int    FP32_BIAS = 127;

  function automatic logic is_nan(fp32_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(fp32_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic fp32_t relu(fp32_t x);
    return x[31] ? FP32_ZERO : x;
  endfunction

endpackage

// File: rtl/mlp_if.sv
// Loader/consumer bundle for the mlp engine; carries the size parameters.
// slave: clk, rst, enable, data_in, weights1, weights2 in; data_out, done out.
interface two_layer_mlp_if
  import mlp_pkg::*;
#(
  parameter int INPUT_SIZE  = 4,
  parameter int HIDDEN_SIZE = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int COUNT       = 1
) ();

  logic  clk;
  logic  rst;
  logic  enable;
  fp32_t data_in  [COUNT][INPUT_SIZE];
  fp32_t weights1 [INPUT_SIZE][HIDDEN_SIZE];
  fp32_t weights2 [HIDDEN_SIZE][OUTPUT_SIZE];
  fp32_t data_out [COUNT][OUTPUT_SIZE];
  logic  done;

  modport slave (
    input  clk, rst, enable,
    input  data_in, weights1, weights2,
    output data_out, done
  );

  modport master (
    output clk, rst, enable,
    output data_in, weights1, weights2,
    input  data_out, done
  );

endinterface

// File: rtl/mlp_fp32_mac.sv
// Combinational fp32 y = a*b + c, product and sum rounded separately (RNE).
// Ports: a, b, c operands; y result. FTZ, saturating, canonical qNaN.
module fp32_mac
  import mlp_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  input  fp32_t c,
  output fp32_t y
);

  function automatic fp32_t fmul(fp32_t x, fp32_t z);
    logic        s;
    logic [7:0]  ex;
    logic [7:0]  ez;
    logic [47:0] p;
    logic [23:0] m24;
    logic        g;
    logic        st;
    logic        up;
    logic [24:0] m25;
    int          e;
    fp32_t       r;
    s   = x[31] ^ z[31];
    ex  = x[30:23];
    ez  = z[30:23];
    r   = {s, 31'd0};
    p   = '0;
    m24 = '0;
    g   = 1'b0;
    st  = 1'b0;
    up  = 1'b0;
    m25 = '0;
    e   = 0;
    if (is_nan(x) || is_nan(z)) begin
      r = FP32_QNAN;
    end else if (ex == 8'hFF || ez == 8'hFF) begin
      // inf * 0 is invalid; a subnormal counts as zero here
      if (ex == 8'd0 || ez == 8'd0) r = FP32_QNAN;
      else r = {s, 8'hFF, 23'd0};
    end else if (ex == 8'd0 || ez == 8'd0) begin
      r = {s, 31'd0};
    end else begin
      p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, z[22:0]};
      e = int'(ex) + int'(ez) - FP32_BIAS;
      if (p[47]) begin
        m24 = p[47:24];
        g   = p[23];
        st  = |p[22:0];
        e   = e + 1;
      end else begin
        m24 = p[46:23];
        g   = p[22];
        st  = |p[21:0];
      end
      up  = g & (st | m24[0]);
      m25 = {1'b0, m24} + {24'd0, up};
      if (m25[24]) begin
        e   = e + 1;
        m25 = m25 >> 1;
      end
      if (e >= 255) r = {s, 8'hFF, 23'd0};
      else if (e <= 0) r = {s, 31'd0};
      else r = {s, 8'(e), m25[22:0]};
    end
    return r;
  endfunction

  function automatic fp32_t fadd(fp32_t x, fp32_t z);
    fp32_t       hi;
    fp32_t       lo;
    fp32_t       r;
    logic [7:0]  d;
    logic [50:0] ma;
    logic [50:0] mb;
    logic [50:0] sm;
    logic [50:0] nm;
    logic        g;
    logic        st;
    logic        up;
    logic [24:0] m25;
    int          e;
    int          p;
    hi  = x;
    lo  = z;
    r   = FP32_ZERO;
    d   = '0;
    ma  = '0;
    mb  = '0;
    sm  = '0;
    nm  = '0;
    g   = 1'b0;
    st  = 1'b0;
    up  = 1'b0;
    m25 = '0;
    e   = 0;
    p   = 0;
    if (is_nan(x) || is_nan(z)) begin
      r = FP32_QNAN;
    end else if (is_inf(x) && is_inf(z)) begin
      r = (x[31] != z[31]) ? FP32_QNAN : x;
    end else if (is_inf(x)) begin
      r = x;
    end else if (is_inf(z)) begin
      r = z;
    end else if (x[30:23] == 8'd0 && z[30:23] == 8'd0) begin
      r = FP32_ZERO;
    end else if (x[30:23] == 8'd0) begin
      r = z;
    end else if (z[30:23] == 8'd0) begin
      r = x;
    end else begin
      if (z[30:0] > x[30:0]) begin
        hi = z;
        lo = x;
      end
      d  = hi[30:23] - lo[30:23];
      ma = {2'b01, hi[22:0], 26'd0};
      mb = {2'b01, lo[22:0], 26'd0};
      // far-away addend only matters as a sticky bit
      if (d > 8'd26) mb = 51'd1;
      else mb = mb >> d;
      sm = (hi[31] == lo[31]) ? ma + mb : ma - mb;
      if (sm == 51'd0) begin
        r = FP32_ZERO;
      end else begin
        for (int i = 0; i < 51; i++)
          if (sm[i]) p = i;
        nm  = sm << (50 - p);
        e   = int'(hi[30:23]) + p - 49;
        g   = nm[26];
        st  = |nm[25:0];
        up  = g & (st | nm[27]);
        m25 = {1'b0, nm[50:27]} + {24'd0, up};
        if (m25[24]) begin
          e   = e + 1;
          m25 = m25 >> 1;
        end
        if (e >= 255) r = {hi[31], 8'hFF, 23'd0};
        else if (e <= 0) r = {hi[31], 31'd0};
        else r = {hi[31], 8'(e), m25[22:0]};
      end
    end
    return r;
  endfunction

  fp32_t prod;

  always_comb begin
    prod = fmul(a, b);
    y    = fadd(prod, c);
  end

endmodule

// File: rtl/mlp.sv
// Sequential two-layer fp32 perceptron, one MAC per clock: out = act(x*W1)*W2.
// Port: intf (two_layer_mlp_if.slave). Build option MLP_RELU_EN: ReLU hidden.
module mlp
  import mlp_pkg::*;
(
  two_layer_mlp_if.slave intf
);

  localparam int IN   = intf.INPUT_SIZE;
  localparam int HID  = intf.HIDDEN_SIZE;
  localparam int OUT  = intf.OUTPUT_SIZE;
  localparam int CNT  = intf.COUNT;
  localparam int KMAX = (IN > HID) ? IN : HID;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int JMAX = (HID > OUT) ? HID : OUT;
  localparam int JW   = (JMAX > 1) ? $clog2(JMAX) : 1;
  localparam int RW   = (CNT > 1) ? $clog2(CNT) : 1;

  function automatic fp32_t act(fp32_t x);
`ifdef MLP_RELU_EN
    return relu(x);
`else
    return x;
`endif
  endfunction

  mlp_state_e    state_q;
  mlp_state_e    state_d;
  logic          done_q;
  logic [KW-1:0] k_q;
  logic [JW-1:0] j_q;
  logic [RW-1:0] r_q;
  fp32_t         acc_q;
  fp32_t         hid_q  [HID];
  fp32_t         dout_q [CNT][OUT];
  fp32_t         mac_a;
  fp32_t         mac_b;
  fp32_t         mac_y;

  // k counts one past the last term: that slot is the write cycle
  logic k_end1;
  logic k_end2;
  logic j_last;
  logic o_last;
  logic r_last;

  assign k_end1 = (k_q == KW'(IN));
  assign k_end2 = (k_q == KW'(HID));
  assign j_last = (j_q == JW'(HID - 1));
  assign o_last = (j_q == JW'(OUT - 1));
  assign r_last = (r_q == RW'(CNT - 1));

  always_comb begin
    mac_a = FP32_ZERO;
    mac_b = FP32_ZERO;
    for (int r = 0; r < CNT; r++)
      for (int k = 0; k < IN; k++)
        for (int j = 0; j < HID; j++)
          if (state_q == L1 && r_q == RW'(r) &&
              k_q == KW'(k) && j_q == JW'(j)) begin
            mac_a = intf.data_in[r][k];
            mac_b = intf.weights1[k][j];
          end
    for (int k = 0; k < HID; k++)
      for (int o = 0; o < OUT; o++)
        if (state_q == L2 && k_q == KW'(k) &&
            j_q == JW'(o)) begin
          mac_a = hid_q[k];
          mac_b = intf.weights2[k][o];
        end
  end

  fp32_mac u_mac (
    .a (mac_a),
    .b (mac_b),
    .c (acc_q),
    .y (mac_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (intf.enable) state_d = L1;
      L1:   if (k_end1 && j_last) state_d = L2;
      L2:   if (k_end2 && o_last) state_d = r_last ? DONE : L1;
      DONE: if (!intf.enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge intf.clk) begin
    if (intf.rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      acc_q   <= FP32_ZERO;
      k_q     <= '0;
      j_q     <= '0;
      r_q     <= '0;
      for (int h = 0; h < HID; h++)
        hid_q[h] <= FP32_ZERO;
      for (int r = 0; r < CNT; r++)
        for (int o = 0; o < OUT; o++)
          dout_q[r][o] <= FP32_ZERO;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          k_q   <= '0;
          j_q   <= '0;
          r_q   <= '0;
          acc_q <= FP32_ZERO;
        end
        L1: begin
          if (k_end1) begin
            for (int h = 0; h < HID; h++)
              if (j_q == JW'(h)) hid_q[h] <= act(acc_q);
            acc_q <= FP32_ZERO;
            k_q   <= '0;
            j_q   <= j_last ? '0 : j_q + JW'(1);
          end else begin
            acc_q <= mac_y;
            k_q   <= k_q + KW'(1);
          end
        end
        L2: begin
          if (k_end2) begin
            for (int r = 0; r < CNT; r++)
              for (int o = 0; o < OUT; o++)
                if (r_q == RW'(r) && j_q == JW'(o))
                  dout_q[r][o] <= acc_q;
            acc_q <= FP32_ZERO;
            k_q   <= '0;
            if (o_last) begin
              j_q <= '0;
              if (!r_last) r_q <= r_q + RW'(1);
            end else begin
              j_q <= j_q + JW'(1);
            end
          end else begin
            acc_q <= mac_y;
            k_q   <= k_q + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign intf.done     = done_q;
  assign intf.data_out = dout_q;

endmodule

// File: tb/tb_mlp.sv
// Scoreboard bench for mlp: single-sample and two-sample instances.
// Directed vectors with hand-computed fp32 results and latencies.
module tb_mlp;
  import mlp_pkg::*;

  localparam fp32_t F05   = 32'h3F00_0000;
  localparam fp32_t FN05  = 32'hBF00_0000;
  localparam fp32_t F1    = 32'h3F80_0000;
  localparam fp32_t F2    = 32'h4000_0000;
  localparam fp32_t F3    = 32'h4040_0000;
  localparam fp32_t F4    = 32'h4080_0000;
  localparam fp32_t F5    = 32'h40A0_0000;
  localparam fp32_t F25   = 32'h4020_0000;
  localparam fp32_t F1E30 = 32'h7149_F2CA;
  localparam fp32_t SNAN  = 32'h7F80_0001;

  int checks = 0;
  int errors = 0;

  fp32_t exp1_q[$];
  string nm1_q[$];
  fp32_t exp2_q[$];
  string nm2_q[$];

  two_layer_mlp_if #(.COUNT(1)) u1 ();
  two_layer_mlp_if #(.COUNT(2)) u2 ();

  mlp dut1 (.intf(u1));
  mlp dut2 (.intf(u2));

  initial begin
    u1.clk = 1'b0;
    u2.clk = 1'b0;
  end

  always #5 begin
    u1.clk = ~u1.clk;
    u2.clk = ~u2.clk;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // monitors: pop expectations on every rising edge of done
  initial begin : mon1
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge u1.clk);
      if (u1.done === 1'b1 && !prev) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon1 unexpected done got 1 exp 0");
        end else begin
          chk(nm1_q.pop_front(), u1.data_out[0][0],
              exp1_q.pop_front());
        end
      end
      prev = (u1.done === 1'b1);
    end
  end

  initial begin : mon2
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge u2.clk);
      if (u2.done === 1'b1 && !prev) begin
        for (int r = 0; r < 2; r++) begin
          if (exp2_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon2 unexpected done got 1 exp 0");
          end else begin
            chk(nm2_q.pop_front(), u2.data_out[r][0],
                exp2_q.pop_front());
          end
        end
      end
      prev = (u2.done === 1'b1);
    end
  end

  task automatic load1(input fp32_t x0, input fp32_t w00,
                       input fp32_t col1);
    u1.data_in[0][0] = x0;
    u1.data_in[0][1] = F2;
    u1.data_in[0][2] = F3;
    u1.data_in[0][3] = F4;
    for (int k = 0; k < 4; k++) begin
      u1.weights1[k][0] = F05;
      u1.weights1[k][1] = col1;
    end
    u1.weights1[0][0] = w00;
    u1.weights2[0][0] = F05;
    u1.weights2[1][0] = F05;
  endtask

  task automatic run1(input string nm, input fp32_t e,
                      input int hold, input bit toggle);
    int cnt;
    bit seen;
    exp1_q.push_back(e);
    nm1_q.push_back(nm);
    @(negedge u1.clk);
    u1.enable = 1'b1;
    cnt = 0;
    seen = 1'b0;
    while (cnt < 100 && !seen) begin
      @(posedge u1.clk);
      #1;
      cnt++;
      seen = (u1.done === 1'b1);
      if (toggle && cnt == 3) u1.enable = 1'b0;
      if (toggle && cnt == 5) u1.enable = 1'b1;
    end
    chk({nm, " latency"}, cnt, 14);
    for (int i = 0; i < hold; i++) begin
      @(negedge u1.clk);
      chk({nm, " hold done"}, {31'd0, u1.done}, 1);
      chk({nm, " hold data"}, u1.data_out[0][0], e);
    end
    @(negedge u1.clk);
    u1.enable = 1'b0;
    @(posedge u1.clk);
    #1;
    chk({nm, " done clear"}, {31'd0, u1.done}, 0);
  endtask

  initial begin
    int cnt;
    int highs;
    bit seen;
    u1.rst = 1'b1;
    u2.rst = 1'b1;
    u1.enable = 1'b0;
    u2.enable = 1'b0;
    load1(F1, F05, F05);
    for (int k = 0; k < 4; k++) begin
      u2.data_in[0][k] = u1.data_in[0][k];
      u2.data_in[1][k] = FP32_ZERO;
      u2.weights1[k][0] = F05;
      u2.weights1[k][1] = F05;
    end
    u2.weights2[0][0] = F05;
    u2.weights2[1][0] = F05;
    repeat (2) @(posedge u1.clk);
    @(negedge u1.clk);
    u1.rst = 1'b0;
    u2.rst = 1'b0;
    chk("reset done1", {31'd0, u1.done}, 0);
    chk("reset out1", u1.data_out[0][0], FP32_ZERO);
    chk("reset done2", {31'd0, u2.done}, 0);
    chk("reset out2", u2.data_out[1][0], FP32_ZERO);

    run1("basic", F5, 3, 1'b0);

    // abort a run with a one-cycle reset
    @(negedge u1.clk);
    u1.enable = 1'b1;
    repeat (5) @(posedge u1.clk);
    @(negedge u1.clk);
    u1.rst = 1'b1;
    u1.enable = 1'b0;
    @(negedge u1.clk);
    u1.rst = 1'b0;
    chk("abort done", {31'd0, u1.done}, 0);
    chk("abort out", u1.data_out[0][0], FP32_ZERO);
    highs = 0;
    repeat (20) begin
      @(negedge u1.clk);
      if (u1.done === 1'b1) highs++;
    end
    chk("abort idle", highs, 0);

    run1("rerun", F5, 0, 1'b1);

    load1(F1, F05, FN05);
`ifdef MLP_RELU_EN
    run1("neg col", F25, 0, 1'b0);
`else
    run1("neg col", FP32_ZERO, 0, 1'b0);
`endif

    load1(SNAN, F05, F05);
    run1("nan", FP32_QNAN, 0, 1'b0);

    load1(F1E30, F1E30, F05);
    run1("inf", FP32_PINF, 0, 1'b0);

    // two samples back to back
    exp2_q.push_back(F5);
    nm2_q.push_back("cnt2 s0");
    exp2_q.push_back(FP32_ZERO);
    nm2_q.push_back("cnt2 s1");
    @(negedge u2.clk);
    u2.enable = 1'b1;
    cnt = 0;
    seen = 1'b0;
    while (cnt < 100 && !seen) begin
      @(posedge u2.clk);
      #1;
      cnt++;
      seen = (u2.done === 1'b1);
    end
    chk("cnt2 latency", cnt, 27);
    @(negedge u2.clk);
    u2.enable = 1'b0;
    repeat (2) @(negedge u2.clk);
    chk("cnt2 done clear", {31'd0, u2.done}, 0);

    repeat (3) @(negedge u1.clk);
    chk("queue1 empty", exp1_q.size(), 0);
    chk("queue2 empty", exp2_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
